// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the load/store unit.
//   mem_width_e  - access width encoding, shared with the instruction decoder
//   lsu_state_e  - lsu_ctrl FSM states
//   decode_width - maps a raw width field onto mem_width_e (unknown -> WORD)
//   is_misaligned, byte_enables, replicate_wdata - per-width address/lane helpers
package lsu_pkg;

  typedef enum logic [3:0] {
    WIDTH_WORD = 4'b0000,
    WIDTH_HALF = 4'b0101,
    WIDTH_BYTE = 4'b1010
  } mem_width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } lsu_state_e;

  // Any encoding the decoder did not produce is handled as a full word access.
  function automatic mem_width_e decode_width(input logic [3:0] raw);
    case (raw)
      4'b0101: return WIDTH_HALF;
      4'b1010: return WIDTH_BYTE;
      default: return WIDTH_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_width_e w, input logic [1:0] off);
    case (w)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return off[0];
      default:    return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input mem_width_e w, input logic [1:0] off);
    case (w)
      WIDTH_BYTE: return 4'b0001 << off;
      WIDTH_HALF: return 4'b0011 << {off[1], 1'b0};
      default:    return 4'b1111;
    endcase
  endfunction

  // Store data is copied into every lane so the bus only needs byte enables.
  function automatic logic [31:0] replicate_wdata(input mem_width_e w, input logic [31:0] d);
    case (w)
      WIDTH_BYTE: return {4{d[7:0]}};
      WIDTH_HALF: return {2{d[15:0]}};
      default:    return d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane select and sign/zero extension of load data.
//   word_in  - raw 32-bit word from the bus
//   offset   - byte offset of the access within the word
//   width    - access width
//   zero_ext - 1 = zero-extend, 0 = sign-extend (ignored for WORD)
//   data_out - extended load result
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  offset,
  input  mem_width_e  width,
  input  logic        zero_ext,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the word, then extend it to 32 bits.
  always_comb begin
    byte_sel = word_in[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word_in[31:16] : word_in[15:0];
    data_out = word_in;
    case (width)
      WIDTH_BYTE: data_out = zero_ext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      WIDTH_HALF: data_out = zero_ext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:    data_out = word_in;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the execute stage and a simple
// request/ack bus.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   valid_in, mem_read_in,
//   mem_write_in, mem_width_in,
//   mem_zero_extend_in,
//   addr_in, wdata_in           - access request from the pipeline
//   stall_out, done_out         - pipeline hold and one-cycle completion pulse
//   rdata_out                   - extended load result (held between loads)
//   misaligned_out, timeout_out - one-cycle fault pulses (with done_out)
//   bus_*                       - request side and response side of the bus
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        misaligned_out,
  output logic        timeout_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state, state_next;
  logic             accept;
  mem_width_e       in_width;
  logic             in_misaligned;

  logic [29:0]      addr_q;
  logic [1:0]       off_q;
  mem_width_e       width_q;
  logic             zext_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic             fault_mis_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      rdata_q;
  logic [31:0]      aligned_data;
  logic             in_req;

  assign in_width      = decode_width(mem_width_in);
  assign in_misaligned = is_misaligned(in_width, addr_in[1:0]);
  assign in_req        = (state == S_REQ);

  // State register; reset drops straight back to IDLE so a transfer in
  // flight loses its bus request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and control outputs. Acceptance is gated by rst_n so that
  // stall_out stays low while reset is held even if the pipeline is driving
  // a request. Misaligned accesses skip the bus and fault directly.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    stall_out      = 1'b0;
    done_out       = 1'b0;
    misaligned_out = 1'b0;
    timeout_out    = 1'b0;
    bus_req_out    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rst_n && valid_in && (mem_read_in || mem_write_in)) begin
          accept     = 1'b1;
          stall_out  = 1'b1;
          state_next = in_misaligned ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        stall_out   = 1'b1;
        bus_req_out = 1'b1;
        if (bus_ack_in)                  state_next = S_DONE;
        else if (wait_cnt == LAST_WAIT)  state_next = S_FAULT;
      end
      S_DONE: begin
        done_out   = 1'b1;
        state_next = S_IDLE;
      end
      S_FAULT: begin
        done_out       = 1'b1;
        misaligned_out = fault_mis_q;
        timeout_out    = ~fault_mis_q;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Access context is captured once at acceptance and held for the whole
  // transfer, which keeps the bus outputs stable until the ack. The wait
  // counter restarts on every acceptance; only aligned accesses reach REQ,
  // so fault_mis_q is already 0 whenever a timeout can happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      off_q       <= '0;
      width_q     <= WIDTH_WORD;
      zext_q      <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      fault_mis_q <= 1'b0;
      wait_cnt    <= '0;
      rdata_q     <= '0;
    end else if (accept) begin
      addr_q      <= addr_in[31:2];
      off_q       <= addr_in[1:0];
      width_q     <= in_width;
      zext_q      <= mem_zero_extend_in;
      we_q        <= mem_write_in;
      wdata_q     <= wdata_in;
      fault_mis_q <= in_misaligned;
      wait_cnt    <= '0;
    end else if (in_req) begin
      if (bus_ack_in) begin
        if (!we_q) rdata_q <= aligned_data;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  load_align u_load_align (
    .word_in  (bus_rdata_in),
    .offset   (off_q),
    .width    (width_q),
    .zero_ext (zext_q),
    .data_out (aligned_data)
  );

  // Bus request fields are only driven while a request is outstanding.
  assign bus_we_out    = in_req & we_q;
  assign bus_addr_out  = in_req ? {addr_q, 2'b00} : 32'h0;
  assign bus_be_out    = in_req ? byte_enables(width_q, off_q) : 4'h0;
  assign bus_wdata_out = in_req ? replicate_wdata(width_q, wdata_q) : 32'h0;
  assign rdata_out     = (state == S_FAULT) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl. Inputs change and
// outputs are sampled around the falling clock edge.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, mem_read_in, mem_write_in, mem_zero_extend_in;
  logic [3:0]  mem_width_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall_out, done_out, misaligned_out, timeout_out;
  logic [31:0] rdata_out;
  logic        bus_req_out, bus_we_out, bus_ack_in;
  logic [31:0] bus_addr_out, bus_wdata_out, bus_rdata_in;
  logic [3:0]  bus_be_out;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_width_in(mem_width_in),
    .mem_zero_extend_in(mem_zero_extend_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .done_out(done_out), .rdata_out(rdata_out),
    .misaligned_out(misaligned_out), .timeout_out(timeout_out),
    .bus_req_out(bus_req_out), .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_be_out(bus_be_out), .bus_wdata_out(bus_wdata_out),
    .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in)
  );

  // Drives one access request onto the pipeline inputs (no checking).
  task automatic drive_access(input logic rd, input logic wr, input logic [3:0] w,
                              input logic zx, input logic [31:0] a, input logic [31:0] wd);
    valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; mem_width_in = w;
    mem_zero_extend_in = zx; addr_in = a; wdata_in = wd;
  endtask

  task automatic drive_idle();
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; bus_ack_in = 1'b0;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive_idle();
    mem_width_in = 4'b0000; mem_zero_extend_in = 1'b0; addr_in = '0; wdata_in = '0;
    bus_rdata_in = '0;
    step();
    drive_access(1'b1, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    #1;
    n_total++; if (stall_out !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall_out); else n_pass++;
    n_total++; if (bus_req_out !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", bus_req_out); else n_pass++;
    n_total++; if ({done_out, misaligned_out, timeout_out, bus_we_out} !== 4'b0) $display("[TB] FAIL reset_pulses: got %b expected 0000", {done_out, misaligned_out, timeout_out, bus_we_out}); else n_pass++;
    n_total++; if (rdata_out !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata_out); else n_pass++;
    n_total++; if (bus_be_out !== 4'h0 || bus_addr_out !== 32'h0) $display("[TB] FAIL reset_bus: got be %h addr %h expected 0 0", bus_be_out, bus_addr_out); else n_pass++;
    step();
    drive_idle();
    rst_n = 1'b1;
  endtask

  // LB at 0x103 with ack in the second request cycle.
  task automatic test_lb();
    int stalls = 0;
    step();
    drive_access(1'b1, 1'b0, 4'b1010, 1'b0, 32'h103, 32'h0);
    #1; if (stall_out) stalls++;
    n_total++; if (stall_out !== 1'b1) $display("[TB] FAIL lb_accept_stall: got %b expected 1", stall_out); else n_pass++;
    step(); drive_idle(); #1; if (stall_out) stalls++;
    n_total++; if (bus_req_out !== 1'b1) $display("[TB] FAIL lb_req: got %b expected 1", bus_req_out); else n_pass++;
    n_total++; if (bus_be_out !== 4'b1000) $display("[TB] FAIL lb_be: got %b expected 1000", bus_be_out); else n_pass++;
    n_total++; if (bus_addr_out !== 32'h100 || bus_we_out !== 1'b0) $display("[TB] FAIL lb_addr_we: got %h/%b expected 00000100/0", bus_addr_out, bus_we_out); else n_pass++;
    step(); bus_ack_in = 1'b1; bus_rdata_in = 32'h80123456; #1; if (stall_out) stalls++;
    n_total++; if (bus_be_out !== 4'b1000 || bus_req_out !== 1'b1) $display("[TB] FAIL lb_stable: got be %b req %b expected 1000 1", bus_be_out, bus_req_out); else n_pass++;
    step(); bus_ack_in = 1'b0; #1; if (stall_out) stalls++;
    n_total++; if (done_out !== 1'b1) $display("[TB] FAIL lb_done: got %b expected 1", done_out); else n_pass++;
    n_total++; if (rdata_out !== 32'hFFFFFF80) $display("[TB] FAIL lb_rdata: got %h expected ffffff80", rdata_out); else n_pass++;
    n_total++; if (bus_req_out !== 1'b0) $display("[TB] FAIL lb_req_drop: got %b expected 0", bus_req_out); else n_pass++;
    step(); if (stall_out) stalls++;
    n_total++; if (done_out !== 1'b0) $display("[TB] FAIL lb_done_once: got %b expected 0", done_out); else n_pass++;
    n_total++; if (rdata_out !== 32'hFFFFFF80) $display("[TB] FAIL lb_rdata_hold: got %h expected ffffff80", rdata_out); else n_pass++;
    n_total++; if (stalls !== 3) $display("[TB] FAIL lb_stall_cycles: got %0d expected 3", stalls); else n_pass++;
  endtask

  // LHU at 0x102 then LH (signed) at 0x200, ack in the first request cycle.
  task automatic test_half_loads();
    step(); drive_access(1'b1, 1'b0, 4'b0101, 1'b1, 32'h102, 32'h0);
    step(); drive_idle(); bus_ack_in = 1'b1; bus_rdata_in = 32'h80011234; #1;
    n_total++; if (bus_be_out !== 4'b1100) $display("[TB] FAIL lhu_be: got %b expected 1100", bus_be_out); else n_pass++;
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if (rdata_out !== 32'h00008001 || done_out !== 1'b1) $display("[TB] FAIL lhu_rdata: got %h done %b expected 00008001 1", rdata_out, done_out); else n_pass++;
    step(); drive_access(1'b1, 1'b0, 4'b0101, 1'b0, 32'h200, 32'h0);
    step(); drive_idle(); bus_ack_in = 1'b1; bus_rdata_in = 32'h1234F00D; #1;
    n_total++; if (bus_be_out !== 4'b0011) $display("[TB] FAIL lh_be: got %b expected 0011", bus_be_out); else n_pass++;
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if (rdata_out !== 32'hFFFFF00D) $display("[TB] FAIL lh_rdata: got %h expected fffff00d", rdata_out); else n_pass++;
    step();
  endtask

  // SB at 0x201 with read also set (write wins), then SH at 0x302.
  task automatic test_stores();
    step(); drive_access(1'b1, 1'b1, 4'b1010, 1'b0, 32'h201, 32'h123456AB);
    step(); drive_idle(); bus_ack_in = 1'b1; bus_rdata_in = 32'h55555555; #1;
    n_total++; if (bus_we_out !== 1'b1) $display("[TB] FAIL sb_we: got %b expected 1", bus_we_out); else n_pass++;
    n_total++; if (bus_be_out !== 4'b0010) $display("[TB] FAIL sb_be: got %b expected 0010", bus_be_out); else n_pass++;
    n_total++; if (bus_wdata_out !== 32'hABABABAB) $display("[TB] FAIL sb_wdata: got %h expected abababab", bus_wdata_out); else n_pass++;
    n_total++; if (bus_addr_out !== 32'h200) $display("[TB] FAIL sb_addr: got %h expected 00000200", bus_addr_out); else n_pass++;
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if (done_out !== 1'b1 || rdata_out !== 32'hFFFFF00D) $display("[TB] FAIL sb_rdata_kept: got %h done %b expected fffff00d 1", rdata_out, done_out); else n_pass++;
    step(); drive_access(1'b0, 1'b1, 4'b0101, 1'b0, 32'h302, 32'hCAFEBEEF);
    step(); drive_idle(); bus_ack_in = 1'b1; #1;
    n_total++; if (bus_be_out !== 4'b1100 || bus_wdata_out !== 32'hBEEFBEEF) $display("[TB] FAIL sh_lanes: got %b %h expected 1100 beefbeef", bus_be_out, bus_wdata_out); else n_pass++;
    step(); bus_ack_in = 1'b0;
    step();
  endtask

  // Misaligned word, misaligned half, and an unlisted width treated as WORD.
  task automatic test_misaligned();
    logic [3:0]  widths [3] = '{4'b0000, 4'b0101, 4'b0011};
    logic [31:0] addrs  [3] = '{32'h102, 32'h103, 32'h101};
    for (int i = 0; i < 3; i++) begin
      step(); drive_access(1'b1, 1'b0, widths[i], 1'b0, addrs[i], 32'h0);
      #1;
      n_total++; if (stall_out !== 1'b1) $display("[TB] FAIL mis%0d_stall: got %b expected 1", i, stall_out); else n_pass++;
      step(); drive_idle(); #1;
      n_total++; if (bus_req_out !== 1'b0) $display("[TB] FAIL mis%0d_req: got %b expected 0", i, bus_req_out); else n_pass++;
      n_total++; if ({done_out, misaligned_out, timeout_out} !== 3'b110) $display("[TB] FAIL mis%0d_pulses: got %b expected 110", i, {done_out, misaligned_out, timeout_out}); else n_pass++;
      n_total++; if (rdata_out !== 32'h0 || stall_out !== 1'b0) $display("[TB] FAIL mis%0d_rdata: got %h stall %b expected 00000000 0", i, rdata_out, stall_out); else n_pass++;
      step();
      n_total++; if ({done_out, misaligned_out} !== 2'b00) $display("[TB] FAIL mis%0d_once: got %b expected 00", i, {done_out, misaligned_out}); else n_pass++;
    end
  endtask

  // SW with no ack until the timeout, then reset during a later request.
  task automatic test_timeout_and_reset();
    int reqs = 0;
    int unstable = 0;
    logic seen = 1'b0;
    step(); drive_access(1'b0, 1'b1, 4'b0000, 1'b0, 32'h400, 32'h11111111);
    for (int i = 0; i < 40 && !seen; i++) begin
      step(); drive_idle();
      if (bus_req_out) begin
        reqs++;
        if (bus_addr_out !== 32'h400 || bus_be_out !== 4'hF || bus_we_out !== 1'b1) unstable++;
      end
      if (timeout_out) begin
        seen = 1'b1;
        n_total++; if ({bus_req_out, done_out, misaligned_out} !== 3'b010) $display("[TB] FAIL to_pulses: got req/done/mis %b expected 010", {bus_req_out, done_out, misaligned_out}); else n_pass++;
      end
    end
    n_total++; if (seen !== 1'b1) $display("[TB] FAIL to_seen: got %b expected 1 within 40 cycles", seen); else n_pass++;
    n_total++; if (reqs !== 16) $display("[TB] FAIL to_req_cycles: got %0d expected 16", reqs); else n_pass++;
    n_total++; if (unstable !== 0) $display("[TB] FAIL to_stable: got %0d unstable cycles expected 0", unstable); else n_pass++;
    step();
    step(); drive_access(1'b1, 1'b0, 4'b0000, 1'b0, 32'h500, 32'h0);
    step(); drive_idle(); #1;
    n_total++; if (bus_req_out !== 1'b1) $display("[TB] FAIL rst_pre_req: got %b expected 1", bus_req_out); else n_pass++;
    #1 rst_n = 1'b0; #1;
    n_total++; if (bus_req_out !== 1'b0 || stall_out !== 1'b0) $display("[TB] FAIL rst_mid_req: got req %b stall %b expected 0 0", bus_req_out, stall_out); else n_pass++;
    n_total++; if (bus_addr_out !== 32'h0 || bus_be_out !== 4'h0) $display("[TB] FAIL rst_mid_bus: got %h %b expected 00000000 0000", bus_addr_out, bus_be_out); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive_access(1'b1, 1'b0, 4'b1010, 1'b1, 32'h600, 32'h0);
    #1;
    n_total++; if (stall_out !== 1'b1) $display("[TB] FAIL rst_first_accept: got %b expected 1", stall_out); else n_pass++;
    step(); drive_idle(); bus_ack_in = 1'b1; bus_rdata_in = 32'h11223344; #1;
    n_total++; if (bus_req_out !== 1'b1 || bus_addr_out !== 32'h600) $display("[TB] FAIL rst_after_req: got %b %h expected 1 00000600", bus_req_out, bus_addr_out); else n_pass++;
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if (rdata_out !== 32'h00000044) $display("[TB] FAIL lbu_rdata: got %h expected 00000044", rdata_out); else n_pass++;
    step();
  endtask

  // Request held through DONE is not taken until IDLE; ack in IDLE is ignored.
  task automatic test_back_to_back();
    step(); drive_access(1'b1, 1'b0, 4'b0000, 1'b0, 32'h700, 32'h0);
    step(); bus_ack_in = 1'b1; bus_rdata_in = 32'hDEADBEEF;
    drive_access(1'b1, 1'b0, 4'b1010, 1'b0, 32'h705, 32'h0);
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if ({done_out, stall_out} !== 2'b10 || rdata_out !== 32'hDEADBEEF) $display("[TB] FAIL b2b_done: got done/stall %b rdata %h expected 10 deadbeef", {done_out, stall_out}, rdata_out); else n_pass++;
    step();
    n_total++; if ({stall_out, done_out, bus_req_out} !== 3'b100) $display("[TB] FAIL b2b_accept: got %b expected 100", {stall_out, done_out, bus_req_out}); else n_pass++;
    step(); drive_idle(); bus_ack_in = 1'b1; bus_rdata_in = 32'h00007F00; #1;
    n_total++; if (bus_be_out !== 4'b0010 || bus_addr_out !== 32'h704) $display("[TB] FAIL b2b_bus: got %b %h expected 0010 00000704", bus_be_out, bus_addr_out); else n_pass++;
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if (rdata_out !== 32'h0000007F) $display("[TB] FAIL b2b_rdata: got %h expected 0000007f", rdata_out); else n_pass++;
    step(); bus_ack_in = 1'b1; bus_rdata_in = 32'hFFFFFFFF;
    step(); bus_ack_in = 1'b0; #1;
    n_total++; if ({done_out, stall_out} !== 2'b00 || rdata_out !== 32'h0000007F) $display("[TB] FAIL stray_ack: got done/stall %b rdata %h expected 00 0000007f", {done_out, stall_out}, rdata_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half_loads();
    test_stores();
    test_misaligned();
    test_timeout_and_reset();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
